// File: rtl/input_skew_feeder_if.sv
// Bundle of the row-vector handshake and the skewed array-edge outputs of input_skew_feeder.
interface input_skew_feeder_if #(
    parameter int LENGTH    = 8,
    parameter int BIT_WIDTH = 64
);
    logic                        start;
    logic [LENGTH*BIT_WIDTH-1:0] vec_in;
    logic                        vec_valid;
    logic                        vec_ready;
    logic [LENGTH*BIT_WIDTH-1:0] out_data;
    logic [LENGTH-1:0]           out_lane_valid;
    logic                        busy;
    logic                        done;

    modport master (
        output start, vec_in, vec_valid,
        input  vec_ready, out_data, out_lane_valid, busy, done
    );

    modport slave (
        input  start, vec_in, vec_valid,
        output vec_ready, out_data, out_lane_valid, busy, done
    );
endinterface

// File: rtl/input_skew_feeder.sv
// Re-times full row vectors into a diagonal wavefront (lane i delayed i cycles) for the systolic array west edge.
// Optional stall counter output is built when SKEW_FEEDER_STALL_CNT_EN is defined.
module input_skew_feeder #(
    parameter int LENGTH    = 8,
    parameter int BIT_WIDTH = 64,
    parameter int TILE_ROWS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef SKEW_FEEDER_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    input_skew_feeder_if.slave bus
);
    localparam int RW         = $clog2(TILE_ROWS + 1);
    localparam int DW         = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int DRAIN_LAST = (LENGTH >= 2) ? LENGTH - 2 : 0;

    localparam logic [RW-1:0] ROW_LAST_C   = RW'(TILE_ROWS - 1);
    localparam logic [DW-1:0] DRAIN_LAST_C = DW'(DRAIN_LAST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            done_q, done_d;
    logic            accept;
    logic            advance;
    logic [LENGTH*BIT_WIDTH-1:0] out_data_w;
    logic [LENGTH-1:0]           out_vld_w;

    assign accept = bus.vec_valid && (state_q == S_STREAM);
    // One extra shift on the edge after done flushes the final lane word so it shows for one cycle only.
    assign advance = (state_q != S_IDLE) || done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_STREAM;
                    row_cnt_d = '0;
                end
            end
            S_STREAM: begin
                if (accept) begin
                    row_cnt_d = row_cnt_q + 1'b1;
                    if (row_cnt_q == ROW_LAST_C) begin
                        if (LENGTH == 1) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = '0;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST_C) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane i owns a chain of i+1 data/valid registers; bubbles inject zero data.
    for (genvar i = 0; i < LENGTH; i++) begin : g_lane
        logic [BIT_WIDTH-1:0] dat_q [0:i];
        logic                 vld_q [0:i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= i; s++) begin
                    dat_q[s] <= '0;
                    vld_q[s] <= 1'b0;
                end
            end else if (advance) begin
                dat_q[0] <= accept ? bus.vec_in[i*BIT_WIDTH +: BIT_WIDTH] : '0;
                vld_q[0] <= accept;
                for (int s = 1; s <= i; s++) begin
                    dat_q[s] <= dat_q[s-1];
                    vld_q[s] <= vld_q[s-1];
                end
            end
        end

        assign out_data_w[i*BIT_WIDTH +: BIT_WIDTH] = dat_q[i];
        assign out_vld_w[i]                         = vld_q[i];
    end

    assign bus.out_data       = out_data_w;
    assign bus.out_lane_valid = out_vld_w;
    assign bus.vec_ready      = (state_q == S_STREAM);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = done_q;

`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && bus.start) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_STREAM) && !bus.vec_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Stall counter not built in this configuration.
`endif

endmodule
